// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Collects a program arriving as a byte stream (MSB first), packs every
// BPW = IWIDTH/8 bytes into one instruction word and writes it into imem
// at consecutive addresses starting from 0. The processor core is held in
// reset until the last word has been written, so fetch begins at PC 0
// only after the whole program is in place.
module imem_loader #(
  parameter int IWIDTH = 24,  // instruction word width, multiple of 8
  parameter int PWIDTH = 16   // imem address width, same as the fetch PC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [PWIDTH-1:0] nwords_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              we_o,
  output logic [PWIDTH-1:0] waddr_o,
  output logic [IWIDTH-1:0] wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cpu_rst_o
);

  // Bytes per instruction word and the byte counter sized to hold 0..BPW-1.
  localparam int BPW = IWIDTH / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);

  // Loader states.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [PWIDTH-1:0] nwords_q,  nwords_d;   // program length in words
  logic [PWIDTH-1:0] addr_q,    addr_d;     // address of the word being built
  logic [CW-1:0]     bcnt_q,    bcnt_d;     // bytes already shifted into word_q
  logic [IWIDTH-1:0] word_q,    word_d;     // word under assembly
  logic              we_q,      we_d;
  logic [PWIDTH-1:0] waddr_q,   waddr_d;
  logic [IWIDTH-1:0] wdata_q,   wdata_d;
  logic              done_q,    done_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic              accept;      // a byte is consumed at the next edge
  logic [IWIDTH-1:0] word_shift;  // word_q with the incoming byte appended

  // Ready depends only on state, never on byte_valid_i, so the source can
  // use it without creating a combinational loop through the handshake.
  assign byte_ready_o = (state_q == S_LOAD);
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign accept       = byte_ready_o && byte_valid_i;

  // Shift-left-by-a-byte form also works when IWIDTH is exactly 8, where a
  // part-select of the lower IWIDTH-8 bits would be empty.
  assign word_shift = (word_q << 8) | IWIDTH'(byte_i);

  // Next-state and datapath: start handling, byte packing, word write-out.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    nwords_d  = nwords_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    case (state_q)
      // IDLE and DONE share the start sequence, which is what allows a
      // reload straight out of DONE without a global reset.
      S_IDLE, S_DONE: begin
        if (start_i) begin
          nwords_d = nwords_i;
          addr_d   = '0;
          bcnt_d   = '0;
          word_d   = '0;
          state_d  = (nwords_i != '0) ? S_LOAD : S_DONE;
        end
      end

      S_LOAD: begin
        if (accept) begin
          word_d = word_shift;
          if (bcnt_q == LAST_BYTE) begin
            // Last byte of the word: present the write in the very next
            // cycle. The output registers are loaded here so that waddr_o
            // and wdata_o keep this word after we_o drops.
            bcnt_d  = '0;
            state_d = S_WRITE;
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = word_shift;
          end else begin
            bcnt_d = bcnt_q + CW'(1);
          end
        end
      end

      S_WRITE: begin
        // The address only advances when another word follows, so it never
        // wraps even for the largest possible program.
        if (addr_q == nwords_q - PWIDTH'(1)) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + PWIDTH'(1);
          state_d = S_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Core-facing status follows the current state one cycle later.
    done_d    = (state_q == S_DONE);
    cpu_rst_d = (state_q != S_DONE);
  end

  // State and output registers with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      nwords_q  <= '0;
      addr_q    <= '0;
      bcnt_q    <= '0;
      word_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      nwords_q  <= nwords_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      word_q    <= word_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign we_o      = we_q;
  assign waddr_o   = waddr_q;
  assign wdata_o   = wdata_q;
  assign done_o    = done_q;
  assign cpu_rst_o = cpu_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives byte-stream program loads into imem_loader and
// compares every imem write against words assembled from the stimulus bytes.
module tb_imem_loader;

  localparam int IWIDTH = 24;
  localparam int PWIDTH = 16;
  localparam int BPW    = IWIDTH / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [PWIDTH-1:0] nwords_i;
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              we_o;
  logic [PWIDTH-1:0] waddr_o;
  logic [IWIDTH-1:0] wdata_o;
  logic              busy_o;
  logic              done_o;
  logic              cpu_rst_o;

  imem_loader #(.IWIDTH(IWIDTH), .PWIDTH(PWIDTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .nwords_i     (nwords_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cpu_rst_o    (cpu_rst_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [PWIDTH-1:0] addr;
    logic [IWIDTH-1:0] data;
  } wr_t;

  wr_t        got[$];    // writes observed on the imem port
  logic [7:0] stim[$];   // program bytes for the current load
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_checks++;
    if (observed !== expected)
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    else
      n_pass++;
  endtask

  // Record every write pulse, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (we_o) got.push_back('{addr: waddr_o, data: wdata_o});
  end

  // Reset applied immediately at the current time; outputs checked after one edge.
  task automatic apply_reset();
    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_byte_ready", byte_ready_o, 0);
    check("rst_we",         we_o,         0);
    check("rst_waddr",      waddr_o,      0);
    check("rst_wdata",      wdata_o,      0);
    check("rst_busy",       busy_o,       0);
    check("rst_done",       done_o,       0);
    check("rst_cpu_rst",    cpu_rst_o,    1);
    rst_i = 1'b0;
  endtask

  task automatic start_load(input int n);
    @(posedge clk_i); #1;
    start_i  = 1'b1;
    nwords_i = PWIDTH'(n);
    @(posedge clk_i); #1;
    start_i  = 1'b0;
  endtask

  // Stream stim[first..last-1]; optional random gaps in byte_valid_i. A byte
  // counts as taken when valid and ready are both high before the edge.
  task automatic send_bytes(input bit rand_valid, input int first, input int last);
    bit   acc;
    int   guard;
    logic v;
    for (int k = first; k < last; k++) begin
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
        v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        byte_valid_i = v;
        byte_i       = v ? stim[k] : 8'($urandom);
        acc          = v && byte_ready_o;
        @(posedge clk_i); #1;
        guard++;
        if (!acc && guard > 200) begin
          check($sformatf("byte_timeout[%0d]", k), 0, 1);
          byte_valid_i = 1'b0;
          return;
        end
      end
      // A write must follow exactly the byte that completes a word.
      check($sformatf("we_after_byte[%0d]", k), we_o, ((k + 1) % BPW) == 0);
      if (((k + 1) % BPW) == 0)
        check($sformatf("ready_in_write[%0d]", k), byte_ready_o, 0);
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk_i);
  endtask

  // Reference: word i is bytes i*BPW .. i*BPW+BPW-1 read big-endian, at address i.
  task automatic compare_writes(input int n);
    logic [IWIDTH-1:0] exp_word;
    check("write_count", got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      exp_word = '0;
      for (int b = 0; b < BPW; b++) exp_word = exp_word * 256 + IWIDTH'(stim[i*BPW + b]);
      check($sformatf("waddr[%0d]", i), got[i].addr, i);
      check($sformatf("wdata[%0d]", i), got[i].data, exp_word);
    end
  endtask

  task automatic random_stim(input int nbytes);
    stim.delete();
    for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; nwords_i = '0; byte_i = '0; byte_valid_i = 1'b0;
    @(posedge clk_i); #1;
    apply_reset();

    // Directed two-word load, bytes back-to-back.
    got.delete();
    stim = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    start_load(2);
    check("busy_in_load",    busy_o,    1);
    check("cpu_rst_in_load", cpu_rst_o, 1);
    send_bytes(1'b0, 0, 6);
    wait_done();
    compare_writes(2);
    check("done_after_load",    done_o,    1);
    check("cpu_rst_after_load", cpu_rst_o, 0);
    check("busy_after_load",    busy_o,    0);

    // Same program with random gaps in byte_valid_i, reloaded from DONE.
    got.delete();
    start_load(2);
    send_bytes(1'b1, 0, 6);
    wait_done();
    compare_writes(2);

    // Zero-length program goes straight to DONE without a write.
    apply_reset();
    got.delete();
    start_load(0);
    check("busy_nwords0", busy_o, 0);
    wait_done();
    compare_writes(0);
    check("done_nwords0",    done_o,    1);
    check("cpu_rst_nwords0", cpu_rst_o, 0);

    // Reset after two bytes of the first word discards the partial word.
    apply_reset();
    got.delete();
    random_stim(6);
    start_load(2);
    send_bytes(1'b0, 0, 2);
    apply_reset();
    repeat (3) @(negedge clk_i);
    check("no_partial_write", got.size(), 0);
    random_stim(3);
    start_load(1);
    send_bytes(1'b1, 0, 3);
    wait_done();
    compare_writes(1);

    // A second start pulse in the middle of a load is ignored.
    got.delete();
    random_stim(9);
    start_load(3);
    send_bytes(1'b1, 0, 4);
    check("busy_mid_load", busy_o, 1);
    start_i  = 1'b1;
    nwords_i = PWIDTH'(1);
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    send_bytes(1'b1, 4, 9);
    wait_done();
    compare_writes(3);

    // Reload from DONE: core goes back into reset while the program is written.
    got.delete();
    stim = '{8'h00, 8'h00, 8'h01};
    start_load(1);
    @(posedge clk_i); #1;
    check("cpu_rst_reload", cpu_rst_o, 1);
    check("done_reload",    done_o,    0);
    send_bytes(1'b0, 0, 3);
    check("cpu_rst_reload_write", cpu_rst_o, 1);
    wait_done();
    compare_writes(1);
    check("cpu_rst_reload_done", cpu_rst_o, 0);

    // Random programs, each reloaded straight from DONE.
    for (int it = 0; it < 4; it++) begin
      int n;
      n = $urandom_range(1, 5);
      got.delete();
      random_stim(n * BPW);
      start_load(n);
      send_bytes(1'b1, 0, n * BPW);
      wait_done();
      compare_writes(n);
      check($sformatf("cpu_rst_rand[%0d]", it), cpu_rst_o, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
